regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two sources:
  - the in-order pipeline WB stage, which cannot be back-pressured;
  - a multi-cycle result source (divider / late load), using a valid/ready handshake.
- Buffers multi-cycle results in a small FIFO and drains them into idle WB slots.
- Requests a pipeline stall on starvation, and flags reads/writes of registers whose write is still pending.
- Sits between the WB stage, the multi-cycle unit, the hazard unit and the register file write port.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/rf_wr_fifo.sv | 70 +++++++
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
//   XLEN        : datapath width
//   xlen_t      : one register-wide value
//   reg_addr_t  : architectural register index (x0..x31)
//   rf_wr_req_t : one pending register-file write {rd, data}
//   REG_ZERO    : index of the hard-wired zero register
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [4:0]      reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO of pending register-file writes with per-entry rd compare.
//   clk, rst          : clock, synchronous active-high reset (empties the FIFO)
//   push, push_req    : append push_req at the tail (caller guarantees not full)
//   pop               : drop the head entry (caller guarantees not empty)
//   head              : current head entry
//   count             : occupancy, 0..DEPTH
//   chk_a/chk_b/chk_c : register addresses to look up among live entries
//   hit               : per-slot flag, live entry whose rd equals a non-zero chk_*
module rf_wr_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  rf_wr_req_t             push_req,
  input  logic                   pop,
  output rf_wr_req_t             head,
  output logic [$clog2(DEPTH):0] count,
  input  reg_addr_t              chk_a,
  input  reg_addr_t              chk_b,
  input  reg_addr_t              chk_c,
  output logic [DEPTH-1:0]       hit
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  rf_wr_req_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: liveness is derived from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign head = mem[rd_ptr];

  // A slot is live when its distance from the read pointer (mod DEPTH) is
  // below the occupancy; this also covers the full case where rd_ptr==wr_ptr.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(PW'(PW'(i) - rd_ptr)) < count) begin
        hit[i] = (chk_a != REG_ZERO && chk_a == mem[i].rd) ||
                 (chk_b != REG_ZERO && chk_b == mem[i].rd) ||
                 (chk_c != REG_ZERO && chk_c == mem[i].rd);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the WB stage and a multi-cycle unit.
//   clk, rst                   : clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data     : WB stage result (never back-pressured, wins the port)
//   mc_valid/mc_ready/mc_rd/mc_data : multi-cycle result handshake into the FIFO
//   rf_we/rf_rd_addr/rf_rd_data: register-file write port
//   wb_stall                   : asks the hazard unit for a WB bubble (FIFO starving)
//   chk_rs1/chk_rs2/chk_rd     : decode-stage addresses checked against pending writes
//   pend_hit                   : some non-zero chk_* matches a buffered rd
//   buf_count                  : FIFO occupancy
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       mc_valid,
  output logic                       mc_ready,
  input  logic [4:0]                 mc_rd,
  input  logic [XLEN-1:0]            mc_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_rd_addr,
  output logic [XLEN-1:0]            rf_rd_data,
  output logic                       wb_stall,
  input  logic [4:0]                 chk_rs1,
  input  logic [4:0]                 chk_rs2,
  input  logic [4:0]                 chk_rd,
  output logic                       pend_hit,
  output logic [$clog2(BUF_DEPTH):0] buf_count
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic                 fifo_empty;
  logic                 wb_take;
  logic                 push;
  logic                 pop;
  rf_wr_req_t           head;
  rf_wr_req_t           push_req;
  logic [BUF_DEPTH-1:0] hit;
  logic [SW-1:0]        starve_cnt;
  logic [SW-1:0]        starve_nxt;

  assign fifo_empty = (buf_count == '0);
  assign mc_ready   = !rst && (buf_count < CW'(BUF_DEPTH));
  // Writes to x0 complete the handshake but are never buffered.
  assign push       = mc_valid && mc_ready && (mc_rd != REG_ZERO);
  // A WB write to x0 leaves the slot free for the FIFO head.
  assign wb_take    = wb_valid && (wb_rd != REG_ZERO);
  assign pop        = !rst && !wb_take && !fifo_empty;
  assign push_req   = '{rd: mc_rd, data: mc_data};
  assign pend_hit   = !rst && (|hit);

  rf_wr_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .count    (buf_count),
    .chk_a    (chk_rs1),
    .chk_b    (chk_rs2),
    .chk_c    (chk_rd),
    .hit      (hit)
  );

  always_comb begin
    rf_we      = 1'b0;
    rf_rd_addr = '0;
    rf_rd_data = '0;
    if (!rst) begin
      if (wb_take) begin
        rf_we      = 1'b1;
        rf_rd_addr = wb_rd;
        rf_rd_data = wb_data;
      end else if (pop) begin
        rf_we      = 1'b1;
        rf_rd_addr = head.rd;
        rf_rd_data = head.data;
      end
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || fifo_empty)
      starve_nxt = '0;
    else if (starve_cnt != SW'(STARVE_LIMIT))
      starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      if (pop)
        wb_stall <= 1'b0;
      else if (starve_nxt == SW'(STARVE_LIMIT))
        wb_stall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        wb_stall;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        pend_hit;
  logic [$clog2(DEPTH):0] buf_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  regfile_wb_arbiter #(
    .BUF_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .mc_valid   (mc_valid),
    .mc_ready   (mc_ready),
    .mc_rd      (mc_rd),
    .mc_data    (mc_data),
    .rf_we      (rf_we),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .wb_stall   (wb_stall),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .chk_rd     (chk_rd),
    .pend_hit   (pend_hit),
    .buf_count  (buf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes plus a count of undrained cycles.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   starve = 0;
  bit   stall  = 1'b0;

  // Inputs are stable from posedge+1 to the next posedge, so the negedge sees
  // this cycle's combinational outputs; the model then advances to the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit          wbw, pop, ready, hit, pushed;
      logic [4:0]  eaddr;
      logic [31:0] edata;
      ready = !rst && (q.size() < DEPTH);
      wbw   = wb_valid && (wb_rd != 0);
      pop   = !rst && !wbw && (q.size() > 0);
      eaddr = 0;
      edata = 0;
      if (!rst && wbw) begin
        eaddr = wb_rd;  edata = wb_data;
      end else if (pop) begin
        eaddr = q[0].rd; edata = q[0].data;
      end
      hit = 1'b0;
      if (!rst)
        foreach (q[k])
          if ((chk_rs1 != 0 && chk_rs1 == q[k].rd) ||
              (chk_rs2 != 0 && chk_rs2 == q[k].rd) ||
              (chk_rd  != 0 && chk_rd  == q[k].rd)) hit = 1'b1;

      check("m_rf_we",     32'(rf_we),      32'(!rst && (wbw || pop)));
      check("m_rf_addr",   32'(rf_rd_addr), 32'(eaddr));
      check("m_rf_data",   rf_rd_data,      edata);
      check("m_mc_ready",  32'(mc_ready),   32'(ready));
      check("m_wb_stall",  32'(wb_stall),   32'(stall));
      check("m_pend_hit",  32'(pend_hit),   32'(hit));
      check("m_buf_count", 32'(buf_count),  32'(q.size()));

      if (rst) begin
        q.delete();
        starve = 0;
        stall  = 1'b0;
      end else begin
        pushed = mc_valid && ready && (mc_rd != 0);
        if (pop || q.size() == 0) starve = 0;
        else if (starve < LIMIT)  starve++;
        stall = pop ? 1'b0 : (stall || starve == LIMIT);
        if (pop)    void'(q.pop_front());
        if (pushed) q.push_back('{rd: mc_rd, data: mc_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_mc(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mc_valid = v; mc_rd = rd; mc_data = d;
  endtask

  initial begin
    rst = 1'b1;
    set_wb(0, 0, 0);
    set_mc(0, 0, 0);
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_count", 32'(buf_count), 0);
    check("reset_stall", 32'(wb_stall), 0);
    check("reset_we",    32'(rf_we), 0);

    // WB only
    set_wb(1, 5, 32'hDEADBEEF);
    #1;
    check("wb_we",   32'(rf_we), 1);
    check("wb_addr", 32'(rf_rd_addr), 5);
    check("wb_data", rf_rd_data, 32'hDEADBEEF);
    check("wb_cnt",  32'(buf_count), 0);
    tick();

    // MC only, pipeline idle
    set_wb(0, 0, 0);
    set_mc(1, 7, 32'h1234);
    #1;
    check("mc_ready0", 32'(mc_ready), 1);
    check("mc_we0",    32'(rf_we), 0);
    tick();
    set_mc(0, 0, 0);
    #1;
    check("mc_cnt1", 32'(buf_count), 1);
    check("mc_we",   32'(rf_we), 1);
    check("mc_addr", 32'(rf_rd_addr), 7);
    check("mc_data", rf_rd_data, 32'h1234);
    tick();
    check("mc_cnt0", 32'(buf_count), 0);

    // Collision
    set_wb(1, 3, 32'hA);
    set_mc(1, 4, 32'hB);
    #1;
    check("col_addr", 32'(rf_rd_addr), 3);
    check("col_data", rf_rd_data, 32'hA);
    tick();
    set_wb(0, 0, 0);
    set_mc(0, 0, 0);
    #1;
    check("col2_we",   32'(rf_we), 1);
    check("col2_addr", 32'(rf_rd_addr), 4);
    check("col2_data", rf_rd_data, 32'hB);
    tick();

    // Full / backpressure
    set_wb(1, 1, 32'h11);
    set_mc(1, 8, 32'h80);
    tick();
    set_mc(1, 9, 32'h90);
    tick();
    set_mc(1, 10, 32'hA0);
    #1;
    check("full_cnt",   32'(buf_count), 2);
    check("full_ready", 32'(mc_ready), 0);
    tick();
    check("held_cnt", 32'(buf_count), 2);
    set_wb(0, 0, 0);
    set_mc(0, 0, 0);
    #1;
    check("drain1_addr", 32'(rf_rd_addr), 8);
    check("drain1_data", rf_rd_data, 32'h80);
    tick();
    check("drain2_addr",  32'(rf_rd_addr), 9);
    check("drain2_ready", 32'(mc_ready), 1);
    tick();
    check("drain_cnt", 32'(buf_count), 0);

    // Starvation
    set_wb(1, 2, 32'h22);
    set_mc(1, 11, 32'hB0);
    tick();
    set_mc(0, 0, 0);
    check("starve_s0", 32'(wb_stall), 0);
    tick(); tick(); tick();
    check("starve_s3", 32'(wb_stall), 0);
    tick();
    check("starve_s4", 32'(wb_stall), 1);
    set_wb(0, 0, 0);
    #1;
    check("starve_we",   32'(rf_we), 1);
    check("starve_addr", 32'(rf_rd_addr), 11);
    tick();
    check("starve_clr", 32'(wb_stall), 0);
    check("starve_cnt", 32'(buf_count), 0);

    // x0 push
    set_mc(1, 0, 32'h5);
    #1;
    check("x0_we", 32'(rf_we), 0);
    tick();
    set_mc(0, 0, 0);
    #1;
    check("x0_cnt", 32'(buf_count), 0);
    check("x0_we2", 32'(rf_we), 0);

    // pend_hit
    set_wb(1, 1, 32'h1);
    set_mc(1, 9, 32'h99);
    tick();
    set_mc(0, 0, 0);
    chk_rs1 = 9;
    #1;
    check("pend_hit1", 32'(pend_hit), 1);
    chk_rs1 = 0; chk_rs2 = 3; chk_rd = 4;
    #1;
    check("pend_miss", 32'(pend_hit), 0);
    set_wb(0, 0, 0);
    chk_rs1 = 9; chk_rs2 = 0; chk_rd = 0;
    #1;
    check("pend_popcyc", 32'(pend_hit), 1);
    check("pend_popadr", 32'(rf_rd_addr), 9);
    tick();
    check("pend_after", 32'(pend_hit), 0);
    chk_rs1 = 0;

    // Reset with two entries buffered
    set_wb(1, 1, 32'h1);
    set_mc(1, 12, 32'hC0);
    tick();
    set_mc(1, 13, 32'hD0);
    tick();
    set_mc(0, 0, 0);
    check("rst_pre_cnt", 32'(buf_count), 2);
    rst = 1'b1;
    set_wb(0, 0, 0);
    chk_rs1 = 12;
    #1;
    check("rst_we",    32'(rf_we), 0);
    check("rst_ready", 32'(mc_ready), 0);
    check("rst_pend",  32'(pend_hit), 0);
    tick();
    rst = 1'b0;
    chk_rs1 = 0;
    #1;
    check("rst_cnt",   32'(buf_count), 0);
    check("rst_stall", 32'(wb_stall), 0);
    check("rst_we2",   32'(rf_we), 0);
    tick();

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      wb_valid = ($urandom_range(0, 99) < 60);
      wb_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data  = $urandom;
      mc_valid = ($urandom_range(0, 99) < 45);
      mc_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      mc_data  = $urandom;
      chk_rs1  = 5'($urandom_range(0, 15));
      chk_rs2  = 5'($urandom_range(0, 15));
      chk_rd   = 5'($urandom_range(0, 15));
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
